ram_stream_fifo_ctrl: RTL

- Controller that turns the single-port 16x128 digit RAM into a streaming FIFO for the online-multiplier datapath.
- Accepts partial-product/digit words from the upstream stage over valid/ready and issues RAM writes.
- Schedules RAM reads and absorbs the RAM's one-cycle registered-address read latency in a 2-entry output buffer.
- Presents words in order to the downstream stage over valid/ready.
- Sits directly in front of the RAM, owning its data/addr/we ports and consuming q.

---
 rtl/ram_stream_fifo_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/ram_stream_fifo_ctrl.sv
// ram_stream_fifo_ctrl
// Wraps a single-port registered-read RAM as a streaming FIFO. Upstream words
// are written into the RAM. Reads are scheduled so that returning data always
// has a free slot in a 2-entry output buffer, which hides the RAM read latency.
// When both sides want the RAM port, reads and writes alternate.
`timescale 1ns/1ps

module ram_stream_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_count;
    logic                  rd_inflight;
    logic                  prio_rd;
    logic [DATA_WIDTH-1:0] obuf0;
    logic [DATA_WIDTH-1:0] obuf1;
    logic [1:0]            obuf_count;

    logic [DATA_WIDTH-1:0] obuf0_next;
    logic [DATA_WIDTH-1:0] obuf1_next;
    logic [1:0]            obuf_count_next;

    logic full;
    logic rd_req;
    logic rd_grant;
    logic wr_fire;
    logic pop;

    // A read may only be issued when its returning word is guaranteed a slot.
    assign full     = (ram_count == DEPTH);
    assign rd_req   = (ram_count != '0) &&
                      (({1'b0, obuf_count} + {2'b00, rd_inflight}) < 3'd2);
    assign rd_grant = rd_req && (!in_valid || prio_rd || full);
    assign in_ready = !reset && !rd_grant && !full;
    assign wr_fire  = in_valid && in_ready;

    assign ram_we   = wr_fire;
    assign ram_addr = rd_grant ? rd_ptr : wr_ptr;
    assign ram_data = in_data;

    assign out_valid = (obuf_count != 2'd0);
    assign out_data  = obuf0;
    assign pop       = out_valid && out_ready;

    assign level = ram_count
                 + {{ADDR_WIDTH{1'b0}}, rd_inflight}
                 + {{(ADDR_WIDTH-1){1'b0}}, obuf_count};

    // Output buffer next state: pop shifts the head out, and a returning read
    // lands in the first free slot left after any pop.
    always_comb begin
        obuf0_next      = obuf0;
        obuf1_next      = obuf1;
        obuf_count_next = obuf_count;
        if (pop) begin
            obuf0_next      = obuf1;
            obuf_count_next = obuf_count_next - 2'd1;
        end
        if (rd_inflight) begin
            if (obuf_count_next == 2'd0) begin
                obuf0_next = ram_q;
            end else begin
                obuf1_next = ram_q;
            end
            obuf_count_next = obuf_count_next + 2'd1;
        end
    end

    // Pointer, occupancy, arbitration and output buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_count   <= '0;
            rd_inflight <= 1'b0;
            prio_rd     <= 1'b0;
            obuf0       <= '0;
            obuf1       <= '0;
            obuf_count  <= 2'd0;
        end else begin
            if (wr_fire) begin
                wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
                ram_count <= ram_count + (ADDR_WIDTH+1)'(1);
                prio_rd   <= 1'b1;
            end else if (rd_grant) begin
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                ram_count <= ram_count - (ADDR_WIDTH+1)'(1);
                prio_rd   <= 1'b0;
            end
            rd_inflight <= rd_grant;
            obuf0       <= obuf0_next;
            obuf1       <= obuf1_next;
            obuf_count  <= obuf_count_next;
        end
    end

endmodule
